// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the shared CPU memory bus.
// One transaction in flight at a time; a silent slave is cut off by a response timeout.
//
//   state | meaning
//   IDLE  | no owner, bus outputs 0, arbitrate pending requests
//   ISSUE | one cycle, o_bus_DV=1 with the registered request
//   WAIT  | request held on the bus, counting toward timeout
//   RESP  | one cycle, owner's o_mX_DV=1, bus payload outputs 0
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_m0_req,
  input  logic [ADDR_W-1:0] i_m0_address,
  input  logic [DATA_W-1:0] i_m0_data,
  input  logic [2:0]        i_m0_bhw,
  input  logic              i_m0_write_notread,
  output logic [DATA_W-1:0] o_m0_data,
  output logic              o_m0_DV,
  output logic              o_m0_err,
  input  logic              i_m1_req,
  input  logic [ADDR_W-1:0] i_m1_address,
  input  logic [DATA_W-1:0] i_m1_data,
  input  logic [2:0]        i_m1_bhw,
  input  logic              i_m1_write_notread,
  output logic [DATA_W-1:0] o_m1_data,
  output logic              o_m1_DV,
  output logic              o_m1_err,
  output logic [ADDR_W-1:0] o_bus_address,
  output logic [DATA_W-1:0] o_bus_data,
  output logic [2:0]        o_bus_bhw,
  output logic              o_bus_write_notread,
  output logic              o_bus_DV,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic              i_bus_DV,
  output logic [1:0]        o_grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Last WAIT cycle before the timeout response is forced.
  localparam logic [TO_W-1:0] TERM_CNT = TO_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic              last, owner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        bhw_q;
  logic              wnr_q;
  logic [TO_W-1:0]   cnt;
  logic              err_q;
  logic              grant_now, grant_sel, capture, time_out;

  always_comb begin
    grant_sel = 1'b0;
    if (i_m0_req && i_m1_req) grant_sel = ~last;
    else if (i_m1_req)        grant_sel = 1'b1;
    grant_now = (state == IDLE) && (i_m0_req || i_m1_req);
    capture   = ((state == ISSUE) || (state == WAIT)) && i_bus_DV;
    time_out  = (state == WAIT) && !i_bus_DV && (cnt == TERM_CNT);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_now) state_nx = ISSUE;
      ISSUE:   state_nx = i_bus_DV ? RESP : WAIT;
      WAIT:    if (capture || time_out) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last      <= 1'b1;
      owner     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      bhw_q     <= '0;
      wnr_q     <= 1'b0;
      cnt       <= '0;
      err_q     <= 1'b0;
      o_m0_data <= '0;
      o_m1_data <= '0;
    end else begin
      if (grant_now) begin
        owner  <= grant_sel;
        last   <= grant_sel;
        addr_q <= grant_sel ? i_m1_address       : i_m0_address;
        data_q <= grant_sel ? i_m1_data          : i_m0_data;
        bhw_q  <= grant_sel ? i_m1_bhw           : i_m0_bhw;
        wnr_q  <= grant_sel ? i_m1_write_notread : i_m0_write_notread;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      // A response on the terminal cycle takes precedence over the timeout.
      if (capture || time_out) begin
        err_q <= ~capture;
        if (owner) o_m1_data <= capture ? i_bus_data : '0;
        else       o_m0_data <= capture ? i_bus_data : '0;
      end
    end
  end

  always_comb begin
    o_bus_address       = '0;
    o_bus_data          = '0;
    o_bus_bhw           = '0;
    o_bus_write_notread = 1'b0;
    o_bus_DV            = 1'b0;
    o_grant             = 2'b00;
    o_m0_DV             = 1'b0;
    o_m1_DV             = 1'b0;
    o_m0_err            = 1'b0;
    o_m1_err            = 1'b0;
    if ((state == ISSUE) || (state == WAIT)) begin
      o_bus_address       = addr_q;
      o_bus_data          = data_q;
      o_bus_bhw           = bhw_q;
      o_bus_write_notread = wnr_q;
    end
    o_bus_DV = (state == ISSUE);
    if (state != IDLE) o_grant = owner ? 2'b10 : 2'b01;
    if (state == RESP) begin
      o_m0_DV  = ~owner;
      o_m1_DV  = owner;
      o_m0_err = ~owner & err_q;
      o_m1_err = owner & err_q;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter with TIMEOUT=4: table of single transactions,
// then spurious-response, async-reset and back-to-back fairness sequences.
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_wnr, m0_dv, m0_err;
  logic [AW-1:0] m0_address;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [2:0]    m0_bhw;
  logic          m1_req, m1_wnr, m1_dv, m1_err;
  logic [AW-1:0] m1_address;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [2:0]    m1_bhw;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [2:0]    bus_bhw;
  logic          bus_wnr, bus_dv, bus_rsp;
  logic [1:0]    grant;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_req(m0_req), .i_m0_address(m0_address), .i_m0_data(m0_wdata),
    .i_m0_bhw(m0_bhw), .i_m0_write_notread(m0_wnr),
    .o_m0_data(m0_rdata), .o_m0_DV(m0_dv), .o_m0_err(m0_err),
    .i_m1_req(m1_req), .i_m1_address(m1_address), .i_m1_data(m1_wdata),
    .i_m1_bhw(m1_bhw), .i_m1_write_notread(m1_wnr),
    .o_m1_data(m1_rdata), .o_m1_DV(m1_dv), .o_m1_err(m1_err),
    .o_bus_address(bus_address), .o_bus_data(bus_wdata), .o_bus_bhw(bus_bhw),
    .o_bus_write_notread(bus_wnr), .o_bus_DV(bus_dv),
    .i_bus_data(bus_rdata), .i_bus_DV(bus_rsp), .o_grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0, r1;
    logic [31:0] a0, d0;
    logic [2:0]  b0;
    logic        w0;
    logic [31:0] a1, d1;
    logic [2:0]  b1;
    logic        w1;
    int          dly;     // slave answers this many cycles after ISSUE; -1 = silent
    logic [31:0] sdata;
    logic [1:0]  egrant;
    logic [31:0] edata;
    logic        eerr;
    int          elat;    // cycles from request-high IDLE cycle to o_DV
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] ea, ed, rd;
    logic [2:0]  eb;
    logic        ew, er, got0, got1, done;
    int          cyc, issue_cyc, ndv, bad, lat;
    ea = v.egrant[0] ? v.a0 : v.a1;
    ed = v.egrant[0] ? v.d0 : v.d1;
    eb = v.egrant[0] ? v.b0 : v.b1;
    ew = v.egrant[0] ? v.w0 : v.w1;
    m0_req = v.r0; m0_address = v.a0; m0_wdata = v.d0; m0_bhw = v.b0; m0_wnr = v.w0;
    m1_req = v.r1; m1_address = v.a1; m1_wdata = v.d1; m1_bhw = v.b1; m1_wnr = v.w1;
    issue_cyc = -1; ndv = 0; bad = 0; lat = -1; cyc = 0;
    done = 1'b0; got0 = 1'b0; got1 = 1'b0; rd = '0; er = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      if (cyc == 0) chk($sformatf("v%0d_idle", idx), {grant, bus_dv, bus_address[28:0]}, 32'h0);
      if (cyc == 1) begin
        // owner scribbles on its payload after the grant; the bus must not follow
        m0_address = ~m0_address; m0_wdata = ~m0_wdata; m0_bhw = ~m0_bhw; m0_wnr = ~m0_wnr;
        m1_address = ~m1_address; m1_wdata = ~m1_wdata; m1_bhw = ~m1_bhw; m1_wnr = ~m1_wnr;
      end
      if (bus_dv) begin
        ndv++;
        if (issue_cyc < 0) issue_cyc = cyc;
      end
      if (m0_dv || m1_dv) begin
        done = 1'b1; lat = cyc; got0 = m0_dv; got1 = m1_dv;
        rd = v.egrant[0] ? m0_rdata : m1_rdata;
        er = v.egrant[0] ? m0_err : m1_err;
        if (bus_address != 0 || bus_wdata != 0 || bus_bhw != 0 || bus_wnr || grant !== v.egrant) bad++;
        if (v.egrant[0] ? m1_err : m0_err) bad++;
      end else if (issue_cyc >= 0) begin
        if (bus_address !== ea || bus_wdata !== ed || bus_bhw !== eb || bus_wnr !== ew ||
            grant !== v.egrant) bad++;
      end
      bus_rsp   = (issue_cyc >= 0) && (v.dly >= 0) && (cyc - issue_cyc == v.dly);
      bus_rdata = bus_rsp ? v.sdata : 32'h0BAD_0BAD;
      cyc++;
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.elat));
    chk($sformatf("v%0d_bus_dv_count", idx), 32'(ndv), 32'd1);
    chk($sformatf("v%0d_owner_dv", idx), {30'd0, got1, got0}, {30'd0, v.egrant});
    chk($sformatf("v%0d_rdata", idx), rd, v.edata);
    chk($sformatf("v%0d_err", idx), {31'd0, er}, {31'd0, v.eerr});
    chk($sformatf("v%0d_bus_hold", idx), 32'(bad), 32'd0);
    bus_rsp = 1'b0;
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, ncomp, em;
    vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0,
                3, 32'hDEADBEEF, 2'b01, 32'hDEADBEEF, 1'b0, 5};
    vecs[1] = '{1'b1, 1'b0, 32'h104, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0,
                0, 32'hCAFEF00D, 2'b01, 32'hCAFEF00D, 1'b0, 2};
    vecs[2] = '{1'b0, 1'b1, 32'h0, 32'h0, 3'b000, 1'b0, 32'h2000_0004, 32'h1234_5678, 3'b000, 1'b1,
                2, 32'hA5A5A5A5, 2'b10, 32'hA5A5A5A5, 1'b0, 4};
    vecs[3] = '{1'b1, 1'b1, 32'h300, 32'hAAAA0000, 3'b001, 1'b1, 32'h400, 32'hBBBB0000, 3'b010, 1'b0,
                1, 32'h11111111, 2'b01, 32'h11111111, 1'b0, 3};
    vecs[4] = '{1'b1, 1'b1, 32'h300, 32'hAAAA0000, 3'b001, 1'b1, 32'h400, 32'hBBBB0000, 3'b010, 1'b0,
                0, 32'h22222222, 2'b10, 32'h22222222, 1'b0, 2};
    vecs[5] = '{1'b1, 1'b0, 32'h500, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0,
                -1, 32'hFFFFFFFF, 2'b01, 32'h0, 1'b1, 6};
    vecs[6] = '{1'b1, 1'b0, 32'h600, 32'h0, 3'b010, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0,
                4, 32'h77777777, 2'b01, 32'h77777777, 1'b0, 6};
    vecs[7] = '{1'b0, 1'b0 | 1'b1, 32'h0, 32'h0, 3'b000, 1'b0, 32'h700, 32'h0, 3'b011, 1'b0,
                -1, 32'hFFFFFFFF, 2'b10, 32'h0, 1'b1, 6};

    m0_req = 1'b0; m0_address = '0; m0_wdata = '0; m0_bhw = '0; m0_wnr = 1'b0;
    m1_req = 1'b0; m1_address = '0; m1_wdata = '0; m1_bhw = '0; m1_wnr = 1'b0;
    bus_rsp = 1'b0; bus_rdata = '0;

    #12;
    chk("reset_outputs", {grant, bus_dv, m0_dv, m1_dv, m0_err, m1_err, bus_wnr, bus_address[23:0]}, 32'h0);
    chk("reset_rdata", m0_rdata | m1_rdata, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // response strobe while idle must be ignored
    bus_rsp = 1'b1; bus_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("spurious_idle_grant", {30'd0, grant}, 32'h0);
    @(posedge clk); #1 bus_rsp = 1'b0;
    @(negedge clk);
    chk("spurious_idle_state", {29'd0, grant, bus_dv}, 32'h0);
    chk("m0_data_hold", m0_rdata, 32'h77777777);
    chk("m1_data_hold", m1_rdata, 32'h0);

    // async reset in the middle of a WAIT owned by m0
    m0_req = 1'b1; m0_address = 32'h800; m0_bhw = 3'b010; m0_wnr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_reset_grant", {30'd0, grant}, 32'h1);
    chk("pre_reset_addr", bus_address, 32'h800);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_grant", {30'd0, grant}, 32'h0);
    chk("async_reset_bus", {bus_dv, bus_bhw, bus_address[27:0]}, 32'h0);
    m0_req = 1'b1; m0_address = 32'h900;
    m1_req = 1'b1; m1_address = 32'hA00; m1_bhw = 3'b010; m1_wnr = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // both masters hold requests: m0, m1, m0, m1 with one IDLE cycle between
    ncomp = 0; cyc = 0;
    while (ncomp < 4 && cyc < 40) begin
      @(negedge clk);
      if (m0_dv || m1_dv) begin
        em = ncomp % 2;
        chk($sformatf("fair%0d_who", ncomp), {30'd0, m1_dv, m0_dv}, (em == 1) ? 32'h2 : 32'h1);
        chk($sformatf("fair%0d_data", ncomp), (em == 1) ? m1_rdata : m0_rdata,
            ((em == 1) ? 32'hA00 : 32'h900) ^ 32'hF0F0_0000);
        chk($sformatf("fair%0d_cycle", ncomp), 32'(cyc), 32'(2 + 3 * ncomp));
        ncomp++;
      end
      if (bus_dv)
        chk($sformatf("fair%0d_addr", ncomp), bus_address, (ncomp % 2 == 1) ? 32'hA00 : 32'h900);
      bus_rsp   = bus_dv;
      bus_rdata = bus_address ^ 32'hF0F0_0000;
      cyc++;
    end
    chk("fair_completions", 32'(ncomp), 32'd4);
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0; bus_rsp = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter and sequencer for the single CPU memory bus.
- Master 0 is the CPU memory controller port. Master 1 is a secondary requester: DMA or debug loader.
- Serialises requests onto the shared o_bus_* / i_bus_* interface using round-robin priority, one outstanding transaction at a time.
- Provides a response timeout so a non-answering slave cannot hang the CPU.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- TIMEOUT, 255, max cycles spent in WAIT before error response (1..2^TO_W-1)
- TO_W, 8, timeout counter width

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_m0_req  in  1  master 0 request, level; held until o_m0_DV
- i_m0_address  in  ADDR_W  master 0 address
- i_m0_data  in  DATA_W  master 0 write data
- i_m0_bhw  in  3  master 0 byte/half/word code, passed through unchanged
- i_m0_write_notread  in  1  master 0 direction, 1 = write
- o_m0_data  out  DATA_W  master 0 read data
- o_m0_DV  out  1  master 0 completion pulse
- o_m0_err  out  1  master 0 timeout flag, valid with o_m0_DV
- i_m1_*, o_m1_*  same set as master 0, for master 1
- o_bus_address  out  ADDR_W  slave address
- o_bus_data  out  DATA_W  slave write data
- o_bus_bhw  out  3  slave size code
- o_bus_write_notread  out  1  slave direction
- o_bus_DV  out  1  slave request strobe
- i_bus_data  in  DATA_W  slave read data
- i_bus_DV  in  1  slave response valid
- o_grant  out  2  one-hot current owner, 00 when idle

Behaviour:
- States:
  - IDLE
  - ISSUE: one cycle, o_bus_DV=1
  - WAIT: awaiting i_bus_DV
  - RESP: one cycle, o_mX_DV=1
- Reset, asynchronous and immediate:
  - state=IDLE, all outputs 0, timeout counter 0.
  - Round-robin pointer last=1, so master 0 wins the first tie.
- IDLE:
  - If exactly one request is present, grant it.
  - If both are present, grant the master opposite to last.
  - On grant, register that master's address, data, bhw and write_notread. Set last=granted. Go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - o_bus_* driven from the registered values; o_bus_DV=1 for exactly this cycle.
  - If i_bus_DV=1 in this same cycle, capture i_bus_data and go to RESP.
  - Otherwise go to WAIT with counter=0.
- WAIT:
  - o_bus_* held stable; o_bus_DV=0; counter increments each cycle.
  - i_bus_DV=1: capture i_bus_data into the owner's o_mX_data, err=0, go to RESP.
  - Counter reaches TIMEOUT with no i_bus_DV: o_mX_data=0, err=1, go to RESP.
  - If i_bus_DV=1 coincides with the terminal count, the response wins: err=0.
- RESP:
  - The owner's o_mX_DV=1 for one cycle; o_mX_err valid.
  - o_bus_address, o_bus_data, o_bus_bhw and o_bus_write_notread are 0.
  - Next state is IDLE.
  - The master must sample o_mX_DV and deassert its request by the next edge; a request still high in IDLE is a new transaction.
- o_mX_data for a write is the captured i_bus_data, don't-care to the master. o_mX_data holds its value until the next completion to that master.
- o_grant:
  - One-hot for the owner during ISSUE, WAIT and RESP; 00 in IDLE.
  - The non-owner's o_DV and o_err stay 0.
- Bus outputs in IDLE are 0.
- Spurious i_bus_DV in IDLE or RESP is ignored: no state change, no data capture.
- Request inputs and master payloads are ignored except at the IDLE grant edge. Later changes by the owner do not affect the bus.
- Latency:
  - Minimum req-high to o_DV is 2 cycles (slave answers in ISSUE).
  - In general: 2 + slave wait cycles.
  - Timeout case: TIMEOUT+2 cycles.
- Fairness: with both masters continuously requesting, grants alternate m0, m1, m0, … with no idle cycle between a RESP and the next grant decision (IDLE lasts one cycle).

Test Plan:
- Single read: m0 req addr 0x0000_0100, write_notread=0, bhw=3'b010; slave returns 0xDEADBEEF 3 cycles after o_bus_DV -> exactly one o_bus_DV cycle carrying addr 0x100; o_m0_DV pulses with data 0xDEADBEEF, err=0; o_grant=01 during transaction; o_m1_DV stays 0.
- Same-cycle response: slave drives i_bus_DV during ISSUE -> o_m0_DV exactly 2 cycles after req sampled, correct data, WAIT never entered.
- Simultaneous requests after reset, both held continuously -> grant order m0, m1, m0, m1; each master sees its own address on the bus; no lost or duplicated o_DV.
- Write pass-through: m1 write addr 0x2000_0004, data 0x1234_5678, bhw=3'b000 -> o_bus_* carry exactly those values with o_bus_write_notread=1, held stable until i_bus_DV.
- Timeout with TIMEOUT=4, slave silent -> o_m0_DV with err=1 and data 0 at TIMEOUT+2 cycles after grant. Variant where i_bus_DV lands on the terminal count -> err=0 with the slave's data.
- Reset mid-WAIT: assert i_rst_n=0 asynchronously between edges -> o_bus_DV, o_grant and bus outputs drop to 0 immediately; after release with both requesting, m0 is granted first.
